// File: rtl/mem_bus_sequencer.sv
// mem_bus_sequencer: 3-port 32-bit-over-16-bit memory bus arbiter/sequencer; MEMSEQ_FAIRNESS_EN enables port-1 starvation promotion
module mem_bus_sequencer #(
  parameter int WAIT_CYCLES = 1
`ifdef MEMSEQ_FAIRNESS_EN
  , parameter int STARVE_LIMIT = 4
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req1,
  input  logic [31:0] addr1,
  input  logic        req2_rd,
  input  logic        req2_wr,
  input  logic [31:0] addr2,
  input  logic [31:0] wdata2,
  input  logic [3:0]  be2,
  input  logic        req3,
  input  logic [31:0] addr3,
  output logic [31:0] rdata,
  output logic        done1,
  output logic        done2,
  output logic        done3,
  output logic        blocked1,
  output logic        blocked2,
  output logic        blocked3,
  output logic        busy,
  output logic [31:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        mem_lb,
  output logic        mem_hb
);
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
  localparam logic [3:0] WC = 4'(WAIT_CYCLES);
  state_t state, state_nx;
  logic [1:0] port, gnt;
  logic [31:0] a, wd;
  logic [3:0] be, wcnt;
  logic wr, last, act, hi;
  logic [1:0] bp;
`ifdef MEMSEQ_FAIRNESS_EN
  localparam logic [7:0] SL = 8'(STARVE_LIMIT);
  logic [7:0] starve;
`endif
  always_comb begin
`ifdef MEMSEQ_FAIRNESS_EN
    gnt = (req1 && starve >= SL) ? 2'd1 : req3 ? 2'd3 : (req2_rd | req2_wr) ? 2'd2 : req1 ? 2'd1 : 2'd0;
`else
    gnt = req3 ? 2'd3 : (req2_rd | req2_wr) ? 2'd2 : req1 ? 2'd1 : 2'd0;
`endif
    last = wcnt == WC;
    state_nx = state == IDLE ? (gnt != 2'd0 ? LO : IDLE) :
               state == LO   ? (last ? HI : LO) :
               state == HI   ? (last ? DONE : HI) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      port <= 2'd0;
      a <= 32'd0;
      wd <= 32'd0;
      be <= 4'd0;
      wr <= 1'b0;
      wcnt <= 4'd0;
      rdata <= 32'd0;
`ifdef MEMSEQ_FAIRNESS_EN
      starve <= 8'd0;
`endif
    end else begin
      if (state == IDLE && gnt != 2'd0) begin
        port <= gnt;
        a <= gnt == 2'd3 ? addr3 : gnt == 2'd2 ? addr2 : addr1;
        wr <= gnt == 2'd2 && req2_wr;
        wd <= wdata2;
        be <= be2;
`ifdef MEMSEQ_FAIRNESS_EN
        starve <= gnt == 2'd1 ? 8'd0 : (req1 && starve < SL) ? starve + 8'd1 : starve;
`endif
      end
      wcnt <= (act && !last) ? wcnt + 4'd1 : 4'd0;
      if (state == LO && last) rdata[15:0] <= mem_rdata;
      if (state == HI && last) rdata[31:16] <= mem_rdata;
    end
  end
  always_comb begin
    act = state == LO || state == HI;
    hi = state == HI;
    bp = hi ? be[3:2] : be[1:0];
    mem_addr = act ? (a & 32'hFFFF_FFFE) + {30'd0, hi, 1'b0} : 32'd0;
    mem_rd = act & ~wr;
    mem_wr = act & wr & |bp;
    mem_lb = act & (~wr | bp[0]);
    mem_hb = act & (~wr | bp[1]);
    mem_wdata = (act && wr) ? (hi ? wd[31:16] : wd[15:0]) : 16'd0;
    done1 = state == DONE && port == 2'd1;
    done2 = state == DONE && port == 2'd2;
    done3 = state == DONE && port == 2'd3;
    blocked1 = rst_n & req1 & ~done1;
    blocked2 = rst_n & (req2_rd | req2_wr) & ~done2;
    blocked3 = rst_n & req3 & ~done3;
    busy = state != IDLE;
  end
endmodule

// File: tb/tb_mem_bus_sequencer.sv
// tb_mem_bus_sequencer: directed plus randomized transactions checked against a halfword memory reference model
module tb_mem_bus_sequencer;
  localparam int W = 1;
  localparam int N = W + 1;
  logic clk, rst_n;
  logic req1, req2_rd, req2_wr, req3;
  logic [31:0] addr1, addr2, addr3, wdata2, rdata, mem_addr;
  logic [3:0] be2;
  logic done1, done2, done3, blocked1, blocked2, blocked3, busy;
  logic [15:0] mem_wdata, mem_rdata, bv;
  logic mem_rd, mem_wr, mem_lb, mem_hb;
  int vectors = 0;
  int errs = 0;
  logic [15:0] bus_m [logic [31:0]];
  logic [15:0] ref_m [logic [31:0]];

  mem_bus_sequencer #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .rst_n(rst_n), .req1(req1), .addr1(addr1), .req2_rd(req2_rd), .req2_wr(req2_wr),
    .addr2(addr2), .wdata2(wdata2), .be2(be2), .req3(req3), .addr3(addr3), .rdata(rdata),
    .done1(done1), .done2(done2), .done3(done3), .blocked1(blocked1), .blocked2(blocked2),
    .blocked3(blocked3), .busy(busy), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_lb(mem_lb), .mem_hb(mem_hb)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [15:0] dflt(input logic [31:0] ad);
    return ad[16:1] ^ ad[31:16] ^ 16'hC3A5;
  endfunction
  function automatic logic [15:0] get_bus(input logic [31:0] ad);
    return bus_m.exists(ad) ? bus_m[ad] : dflt(ad);
  endfunction
  function automatic logic [15:0] get_ref(input logic [31:0] ad);
    return ref_m.exists(ad) ? ref_m[ad] : dflt(ad);
  endfunction

  always @(negedge clk) mem_rdata = get_bus(mem_addr);
  always @(posedge clk)
    if (mem_wr) begin
      bv = get_bus(mem_addr);
      if (mem_lb) bv[7:0] = mem_wdata[7:0];
      if (mem_hb) bv[15:8] = mem_wdata[15:8];
      bus_m[mem_addr] = bv;
    end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_txn(input int p, input logic [31:0] ad, input logic w, input logic [31:0] wd,
                         input logic [3:0] b, input bit keep1, input bit also3, input bit drop);
    logic [31:0] lo, hia;
    logic [15:0] v;
    logic [1:0] pr;
    logic h, own;
    lo = ad & 32'hFFFF_FFFE;
    hia = lo + 32'd2;
    addr1 = p == 1 ? ad : $urandom;
    addr2 = p == 2 ? ad : $urandom;
    addr3 = p == 3 ? ad : $urandom;
    wdata2 = wd;
    be2 = b;
    req1 = p == 1 || keep1;
    req2_wr = p == 2 && w;
    req2_rd = p == 2 && !w;
    req3 = p == 3 || also3;
    @(posedge clk);
    for (int k = 0; k < 2 * N; k++) begin
      @(negedge clk);
      if (k == 0) begin
        addr1 = $urandom; addr2 = $urandom; addr3 = $urandom; wdata2 = $urandom; be2 = 4'($urandom);
      end
      if (drop && k == N) begin
        req1 = keep1; req2_wr = 0; req2_rd = 0; req3 = also3;
      end
      #1;
      h = k >= N;
      own = !(drop && h);
      pr = h ? b[3:2] : b[1:0];
      chk("bus_addr", mem_addr, h ? hia : lo);
      chk("bus_ctl", {mem_rd, mem_wr, mem_lb, mem_hb, busy, done1, done2, done3},
          {!w, w && |pr, w ? pr[0] : 1'b1, w ? pr[1] : 1'b1, 1'b1, 3'b000});
      chk("bus_wdata", mem_wdata, w ? (h ? wd[31:16] : wd[15:0]) : 16'h0);
      chk("blocked_busy", {blocked1, blocked2, blocked3},
          {keep1 || (p == 1 && own), p == 2 && own, also3 || (p == 3 && own)});
    end
    @(negedge clk);
    #1;
    chk("done", {done1, done2, done3, busy}, {p == 1, p == 2, p == 3, 1'b1});
    chk("blocked_done", {blocked1, blocked2, blocked3}, {keep1 && p != 1, 1'b0, also3 && p != 3});
    if (!w) chk("rdata", rdata, {get_ref(hia), get_ref(lo)});
    else begin
      v = get_ref(lo);
      if (b[0]) v[7:0] = wd[7:0];
      if (b[1]) v[15:8] = wd[15:8];
      ref_m[lo] = v;
      v = get_ref(hia);
      if (b[2]) v[7:0] = wd[23:16];
      if (b[3]) v[15:8] = wd[31:24];
      ref_m[hia] = v;
    end
    req1 = keep1; req2_wr = 0; req2_rd = 0; req3 = 0;
    @(negedge clk);
    #1;
    chk("idle", {busy, done1, done2, done3, blocked1, blocked2, blocked3}, {4'b0000, keep1, 2'b00});
  endtask

  initial begin
    int p;
    logic w;
    logic [31:0] ad;
    rst_n = 0;
    {req1, req2_rd, req2_wr, req3} = 4'b0;
    {addr1, addr2, addr3, wdata2} = '0;
    be2 = 4'h0;
    #12;
    chk("reset_outputs", {rdata, done1, done2, done3, blocked1, blocked2, blocked3, busy,
        mem_addr, mem_wdata, mem_rd, mem_wr, mem_lb, mem_hb}, '0);
    @(negedge clk);
    rst_n = 1;
    #1;
    bus_m[32'h100] = 16'h3412; bus_m[32'h102] = 16'h7856;
    ref_m[32'h100] = 16'h3412; ref_m[32'h102] = 16'h7856;
    run_txn(1, 32'h100, 0, 0, 4'h0, 0, 0, 0);
    chk("fetch_word", rdata, 32'h7856_3412);
    run_txn(2, 32'h20, 1, 32'hAABB_CCDD, 4'b1100, 0, 0, 0);
    run_txn(3, 32'h20, 0, 0, 4'h0, 0, 0, 0);
    chk("partial_write", rdata, {16'hAABB, dflt(32'h20)});
    run_txn(3, 32'h180, 0, 0, 4'h0, 1, 0, 0);
    run_txn(1, 32'h184, 0, 0, 4'h0, 0, 0, 0);
`ifdef MEMSEQ_FAIRNESS_EN
    for (int i = 0; i < 4; i++) run_txn(3, 32'h1A0 + 32'(4 * i), 0, 0, 4'h0, 1, 0, 0);
    run_txn(1, 32'h1C0, 0, 0, 4'h0, 0, 1, 0);
`endif
    run_txn(3, 32'hFFFF_FFFE, 0, 0, 4'h0, 0, 0, 0);
    run_txn(2, 32'hFFFF_FFFF, 1, 32'h1234_5678, 4'b0111, 0, 0, 0);
    run_txn(1, 32'hFFFF_FFFE, 0, 0, 4'h0, 0, 0, 1);
    addr1 = 32'h140;
    req1 = 1;
    @(posedge clk);
    repeat (N + 1) @(negedge clk);
    #1;
    chk("pre_reset_hi", {mem_rd, busy, mem_addr}, {2'b11, 32'h142});
    #1;
    rst_n = 0;
    #1;
    chk("async_reset", {mem_rd, mem_wr, mem_lb, mem_hb, busy, done1, done2, done3, blocked1, mem_addr}, '0);
    @(negedge clk);
    chk("no_done_after_reset", {done1, busy}, 2'b00);
    rst_n = 1;
    #1;
    run_txn(1, 32'h140, 0, 0, 4'h0, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      p = $urandom_range(1, 3);
      w = p == 2 && $urandom_range(0, 1) == 1;
      ad = (i % 8 == 7) ? 32'hFFFF_FFFE : 32'h100 + 32'($urandom_range(0, 31) * 2);
      ad = ad | 32'($urandom_range(0, 1));
      run_txn(p, ad, w, $urandom, 4'($urandom), 0, 0, $urandom_range(0, 3) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
